// File: rtl/reg_scoreboard_if.sv
// Decode/write-back side of the register scoreboard: issue request, release ports,
// flush, and the scoreboard's status outputs.
interface reg_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 3,
  parameter int NUM_DST  = 2,
  parameter int NUM_WB   = 2
);
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                    issue_valid;
  logic [NUM_SRC-1:0]      issue_src_vld;
  logic [NUM_SRC*RW-1:0]   issue_src;
  logic [NUM_DST-1:0]      issue_dst_vld;
  logic [NUM_DST*RW-1:0]   issue_dst;
  logic                    issue_ready;
  logic [NUM_WB-1:0]       wb_vld;
  logic [NUM_WB*RW-1:0]    wb_reg;
  logic                    flush;
  logic [NUM_REGS-1:0]     busy_vec;
  logic                    underflow_err;
  logic [31:0]             stall_cnt;

  modport master (
    output issue_valid, issue_src_vld, issue_src, issue_dst_vld, issue_dst,
           wb_vld, wb_reg, flush,
    input  issue_ready, busy_vec, underflow_err, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_src_vld, issue_src, issue_dst_vld, issue_dst,
           wb_vld, wb_reg, flush,
    output issue_ready, busy_vec, underflow_err, stall_cnt
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-occupancy scoreboard: one in-flight writer counter per architectural
// register, multi-port claim/release, optional same-cycle write-back bypass.

module reg_scoreboard_lane #(
  parameter int NUM_DST = 2,
  parameter int NUM_WB  = 2,
  parameter int CNT_W   = 2,
  parameter int BYPASS  = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               fire,
  input  logic [NUM_WB-1:0]  wb_hit,
  input  logic [NUM_DST-1:0] dst_hit,
  output logic               busy,
  output logic               src_ok,
  output logic               dst_ok,
  output logic               uf
);
  localparam int AW  = CNT_W + $clog2(NUM_WB + NUM_DST + 1) + 1;
  localparam int MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    rel, clm, cnt_x, left, nxt;

  always_comb begin
    rel = '0;
    clm = '0;
    for (int j = 0; j < NUM_WB; j++)  rel = rel + AW'(wb_hit[j]);
    for (int d = 0; d < NUM_DST; d++) clm = clm + AW'(dst_hit[d]);
    cnt_x  = AW'(cnt_q);
    // releases beyond the live count saturate at zero and flag underflow
    left   = (rel > cnt_x) ? '0 : cnt_x - rel;
    uf     = !flush && (rel > cnt_x);
    dst_ok = (left + clm) <= AW'(MAX);
    src_ok = (cnt_q == '0) || ((BYPASS != 0) && (cnt_x == rel));
    nxt    = left + (fire ? clm : '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   cnt_q <= '0;
    else if (flush) cnt_q <= '0;
    else            cnt_q <= CNT_W'(nxt);
  end

  assign busy = |cnt_q;
endmodule

module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 3,
  parameter int NUM_DST  = 2,
  parameter int NUM_WB   = 2,
  parameter int CNT_W    = 2,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  reg_scoreboard_if.slave  sb
);
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [NUM_REGS-1:0][NUM_WB-1:0]  wb_hit;
  logic [NUM_REGS-1:0][NUM_DST-1:0] dst_hit;
  logic [NUM_REGS-1:0]              busy, src_ok, dst_ok, uf;
  logic                             src_blk, ready, fire;
  logic                             uf_q;
  logic [31:0]                      stall_q;

  // decode every port against every register; duplicates count individually
  always_comb begin
    wb_hit  = '0;
    dst_hit = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int j = 0; j < NUM_WB; j++)
        wb_hit[r][j] = sb.wb_vld[j] && (sb.wb_reg[j*RW +: RW] == RW'(r));
      for (int d = 0; d < NUM_DST; d++)
        dst_hit[r][d] = sb.issue_dst_vld[d] && (sb.issue_dst[d*RW +: RW] == RW'(r));
    end
  end

  always_comb begin
    src_blk = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (sb.issue_src_vld[i] && !src_ok[sb.issue_src[i*RW +: RW]]) src_blk = 1'b1;
  end

  assign ready = !sb.flush && !src_blk && (&dst_ok);
  assign fire  = sb.issue_valid && ready;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_lane
    reg_scoreboard_lane #(
      .NUM_DST(NUM_DST), .NUM_WB(NUM_WB), .CNT_W(CNT_W), .BYPASS(BYPASS)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (sb.flush),
      .fire    (fire),
      .wb_hit  (wb_hit[r]),
      .dst_hit (dst_hit[r]),
      .busy    (busy[r]),
      .src_ok  (src_ok[r]),
      .dst_ok  (dst_ok[r]),
      .uf      (uf[r])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uf_q    <= 1'b0;
      stall_q <= '0;
    end else begin
      uf_q <= uf_q | (|uf);
      if (sb.issue_valid && !ready && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign sb.issue_ready   = ready;
  assign sb.busy_vec      = busy;
  assign sb.underflow_err = uf_q;
  assign sb.stall_cnt     = stall_q;
endmodule
